// File: rtl/pdm_pkg.sv
// Shared constants and width helper for the PDM microphone receiver.
package pdm_pkg;

  localparam int unsigned CIC_ORDER = 3;
  localparam int unsigned OUT_W     = 16;
  localparam int unsigned DC_SHIFT  = 8;
  localparam int unsigned DC_W      = 24;

  localparam int OUT_MAX = (1 << (OUT_W - 1)) - 1;
  localparam int OUT_MIN = -OUT_MAX - 1;

  // CIC accumulator width: order * log2(R) bits of growth plus sign and guard bit.
  function automatic int unsigned cic_width(input int unsigned decim_log2);
    return CIC_ORDER * decim_log2 + 2;
  endfunction

endpackage

// File: rtl/cic_decimator.sv
// Third-order CIC decimator: integrators at bit rate, combs at sample rate,
// then scaling to 16 bits with saturation. The first two outputs are dropped.
module cic_decimator import pdm_pkg::*; #(
  parameter int unsigned DECIM_LOG2 = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_bit,
  output logic signed [OUT_W-1:0] pcm_c,
  output logic                    pcm_valid
);

  localparam int unsigned W     = cic_width(DECIM_LOG2);
  localparam int unsigned SCALE = CIC_ORDER * DECIM_LOG2;
  localparam int unsigned SHR   = (SCALE >= OUT_W - 1) ? SCALE - (OUT_W - 1) : 0;
  localparam int unsigned SHL   = (SCALE <  OUT_W - 1) ? (OUT_W - 1) - SCALE : 0;
  localparam int unsigned XW    = W + SHL;

  typedef logic signed [W-1:0] acc_t;

  acc_t i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  acc_t d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  acc_t y_q, y_d;
  acc_t x_c, c1_c, c2_c, c3_c;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic                  dec_q, dec_d;
  logic [1:0]            fill_q, fill_d;
  logic                  pcm_valid_q, pcm_valid_d;
  logic signed [XW-1:0]  scaled_c;

  // Integrators (wrap-around) and decimation counter, advanced once per PDM bit.
  always_comb begin
    i1_d  = i1_q;
    i2_d  = i2_q;
    i3_d  = i3_q;
    cnt_d = cnt_q;
    dec_d = 1'b0;
    x_c   = in_bit ? acc_t'(1) : acc_t'(-1);
    if (in_valid) begin
      i1_d  = i1_q + x_c;
      i2_d  = i2_q + i1_d;
      i3_d  = i3_q + i2_d;
      cnt_d = cnt_q + DECIM_LOG2'(1);
      dec_d = &cnt_q;
    end
  end

  // Combs run one cycle after the R-th bit; outputs gated until the pipeline has filled.
  always_comb begin
    d1_d        = d1_q;
    d2_d        = d2_q;
    d3_d        = d3_q;
    y_d         = y_q;
    fill_d      = fill_q;
    pcm_valid_d = 1'b0;
    c1_c        = i3_q - d1_q;
    c2_c        = c1_c - d2_q;
    c3_c        = c2_c - d3_q;
    if (dec_q) begin
      d1_d = i3_q;
      d2_d = c1_c;
      d3_d = c2_c;
      y_d  = c3_c;
      if (fill_q == 2'd2) begin
        pcm_valid_d = 1'b1;
      end else begin
        fill_d = fill_q + 2'd1;
      end
    end
  end

  // Scale the decimated value to 16-bit full scale and clamp.
  always_comb begin
    scaled_c = (XW'(y_q) <<< SHL) >>> SHR;
    if (scaled_c > XW'(OUT_MAX)) begin
      pcm_c = OUT_W'(OUT_MAX);
    end else if (scaled_c < XW'(OUT_MIN)) begin
      pcm_c = OUT_W'(OUT_MIN);
    end else begin
      pcm_c = scaled_c[OUT_W-1:0];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q        <= '0;
      i2_q        <= '0;
      i3_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      d3_q        <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      dec_q       <= 1'b0;
      fill_q      <= '0;
      pcm_valid_q <= 1'b0;
    end else begin
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      i3_q        <= i3_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d3_q        <= d3_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      fill_q      <= fill_d;
      pcm_valid_q <= pcm_valid_d;
    end
  end

  assign pcm_valid = pcm_valid_q;

endmodule

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: mic clock generation, input synchronizer, CIC
// decimation and a valid/ready output register with sticky overrun.
// Optional DC blocker enabled by defining PDM_DC_BLOCK_EN.
module pdm_mic_rx import pdm_pkg::*; #(
  parameter int unsigned CLK_DIV    = 40,
  parameter int unsigned DECIM_LOG2 = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    mic_clk,
  input  logic                    mic_data,
  output logic signed [OUT_W-1:0] sample,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun
);

  localparam int unsigned HALF = CLK_DIV / 2;
  localparam int unsigned DW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [DW-1:0]           div_q, div_d;
  logic                    mic_clk_q, mic_clk_d;
  logic [1:0]              sync_q, sync_d;
  logic                    tick_c, cap_c;
  logic signed [OUT_W-1:0] pcm_c;
  logic                    pcm_valid;
  logic                    load_c;
  logic signed [OUT_W-1:0] load_val_c;
  logic signed [OUT_W-1:0] sample_q, sample_d;
  logic                    sample_valid_q, sample_valid_d;
  logic                    overrun_q, overrun_d;

  // Half-period divider toggles mic_clk; a bit is captured on each falling transition.
  always_comb begin
    tick_c    = (div_q == DW'(HALF - 1));
    div_d     = tick_c ? '0 : div_q + DW'(1);
    mic_clk_d = mic_clk_q ^ tick_c;
    cap_c     = tick_c & mic_clk_q;
    sync_d    = {sync_q[0], mic_data};
  end

  cic_decimator #(
    .DECIM_LOG2 (DECIM_LOG2)
  ) u_cic (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (cap_c),
    .in_bit    (sync_q[1]),
    .pcm_c     (pcm_c),
    .pcm_valid (pcm_valid)
  );

`ifdef PDM_DC_BLOCK_EN
  logic signed [DC_W-1:0] dc_x_c, dc_xp_q, dc_xp_d, dc_z_q, dc_z_d;
  logic                   dc_valid_q, dc_valid_d;

  // First-order DC blocker between the CIC and the output register.
  always_comb begin
    dc_x_c     = DC_W'(pcm_c);
    dc_xp_d    = dc_xp_q;
    dc_z_d     = dc_z_q;
    dc_valid_d = pcm_valid;
    if (pcm_valid) begin
      dc_xp_d = dc_x_c;
      dc_z_d  = dc_x_c - dc_xp_q + dc_z_q - (dc_z_q >>> DC_SHIFT);
    end
    load_c = dc_valid_q;
    if (dc_z_q > DC_W'(OUT_MAX)) begin
      load_val_c = OUT_W'(OUT_MAX);
    end else if (dc_z_q < DC_W'(OUT_MIN)) begin
      load_val_c = OUT_W'(OUT_MIN);
    end else begin
      load_val_c = dc_z_q[OUT_W-1:0];
    end
  end

  // DC blocker state.
  always_ff @(posedge clk) begin
    if (rst) begin
      dc_xp_q    <= '0;
      dc_z_q     <= '0;
      dc_valid_q <= 1'b0;
    end else begin
      dc_xp_q    <= dc_xp_d;
      dc_z_q     <= dc_z_d;
      dc_valid_q <= dc_valid_d;
    end
  end
`else
  // CIC output feeds the output register directly.
  always_comb begin
    load_c     = pcm_valid;
    load_val_c = pcm_c;
  end
`endif

  // Output handshake: a new sample always loads; dropping an unconsumed one sets overrun.
  always_comb begin
    sample_d       = sample_q;
    sample_valid_d = sample_valid_q;
    overrun_d      = overrun_q;
    if (sample_valid_q && sample_ready) begin
      sample_valid_d = 1'b0;
    end
    if (load_c) begin
      sample_d       = load_val_c;
      sample_valid_d = 1'b1;
      if (sample_valid_q && !sample_ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  // Registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q          <= '0;
      mic_clk_q      <= 1'b0;
      sync_q         <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      div_q          <= div_d;
      mic_clk_q      <= mic_clk_d;
      sync_q         <= sync_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign mic_clk      = mic_clk_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule
